// File: rtl/vec_mag_stream_core.sv
// vec_mag_stream_core: streaming vector magnitude sqrt(x^2 + y^2) for signed (x, y) pairs.
// The sample is squared in one cycle. A restoring square root then takes COORD_WIDTH cycles.
// The result is held on the output until downstream accepts it.
// Build option: define VEC_MAG_ROUND_EN to round the result to nearest.
// Without it the result is floor(sqrt(S)).
module vec_mag_stream_core #(
    parameter int COORD_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     core_reset_i,
    input  logic                     aclk_en_i,
    input  logic                     s_tvalid_i,
    output logic                     s_tready_o,
    input  logic [2*COORD_WIDTH-1:0] s_tdata_i,
    output logic                     m_tvalid_o,
    input  logic                     m_tready_i,
    output logic [COORD_WIDTH-1:0]   m_tdata_o,
    output logic                     busy_o,
    output logic [31:0]              data_processed_cnt_o,
    output logic                     overflow_x_o,
    output logic                     overflow_y_o
);
    localparam int W  = COORD_WIDTH;
    localparam int RW = W + 2;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_VAL  = {1'b0, {(W-1){1'b1}}};
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SQUARE, ROOT, OUT} state_t;

    state_t          r_state;
    logic [W-1:0]    r_ax;
    logic [W-1:0]    r_ay;
    logic [2*W-1:0]  r_sq;
    logic [RW-1:0]   r_rem;
    logic [W-1:0]    r_root;
    logic [CW-1:0]   r_bit;
    logic            r_tvalid;
    logic [W-1:0]    r_tdata;
    logic [31:0]     r_cnt;

    logic [W-1:0]    w_x;
    logic [W-1:0]    w_y;
    logic            w_x_min;
    logic            w_y_min;
    logic [W-1:0]    w_ax;
    logic [W-1:0]    w_ay;
    logic            w_accept;
    logic [2*W-1:0]  w_sq;
    logic [RW+1:0]   w_trial;
    logic [RW+1:0]   w_test;
    logic [RW-1:0]   w_rem_next;
    logic [W-1:0]    w_root_next;
    logic [W-1:0]    w_result;

    assign w_x      = s_tdata_i[W-1:0];
    assign w_y      = s_tdata_i[2*W-1:W];
    assign w_x_min  = (w_x == MIN_VAL);
    assign w_y_min  = (w_y == MIN_VAL);

    assign s_tready_o   = rst_n & (r_state == IDLE) & aclk_en_i & ~core_reset_i;
    assign w_accept     = s_tvalid_i & s_tready_o;
    assign overflow_x_o = w_accept & w_x_min;
    assign overflow_y_o = w_accept & w_y_min;

    assign m_tvalid_o           = r_tvalid;
    assign m_tdata_o            = r_tdata;
    assign busy_o               = (r_state != IDLE);
    assign data_processed_cnt_o = r_cnt;

    assign w_sq = ({{W{1'b0}}, r_ax} * {{W{1'b0}}, r_ax})
                + ({{W{1'b0}}, r_ay} * {{W{1'b0}}, r_ay});

    // Absolute value of each coordinate; the most negative code saturates to the max positive
    always_comb begin
        w_ax = w_x;
        w_ay = w_y;
        if (w_x_min)     w_ax = MAX_VAL;
        else if (w_x[W-1]) w_ax = -w_x;
        if (w_y_min)     w_ay = MAX_VAL;
        else if (w_y[W-1]) w_ay = -w_y;
    end

    // One restoring square-root step: bring down the next two radicand bits and try to subtract 4*root+1
    always_comb begin
        w_trial     = {r_rem, r_sq[2*W-1 -: 2]};
        w_test      = {2'b00, r_root, 2'b01};
        w_rem_next  = w_trial[RW-1:0];
        w_root_next = {r_root[W-2:0], 1'b0};
        if (w_trial >= w_test) begin
            w_rem_next  = RW'(w_trial - w_test);
            w_root_next = {r_root[W-2:0], 1'b1};
        end
    end

`ifdef VEC_MAG_ROUND_EN
    // The final remainder is S - root^2. Round up when it exceeds root.
    assign w_result = (w_rem_next > {2'b00, w_root_next}) ? (w_root_next + W'(1)) : w_root_next;
`else
    assign w_result = w_root_next;
`endif

    // Control FSM and datapath registers; soft reset wins over the clock enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ax     <= '0;
            r_ay     <= '0;
            r_sq     <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_bit    <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_cnt    <= '0;
        end else if (core_reset_i) begin
            r_state  <= IDLE;
            r_bit    <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_cnt    <= '0;
        end else if (aclk_en_i) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ax    <= w_ax;
                        r_ay    <= w_ay;
                        r_state <= SQUARE;
                    end
                end
                SQUARE: begin
                    r_sq    <= w_sq;
                    r_rem   <= '0;
                    r_root  <= '0;
                    r_bit   <= '0;
                    r_state <= ROOT;
                end
                ROOT: begin
                    r_sq   <= {r_sq[2*W-3:0], 2'b00};
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_bit  <= r_bit + CW'(1);
                    if (r_bit == LAST_BIT) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_result;
                        r_state  <= OUT;
                    end
                end
                OUT: begin
                    if (m_tready_i) begin
                        r_tvalid <= 1'b0;
                        r_tdata  <= '0;
                        r_cnt    <= r_cnt + 32'd1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
